// File: rtl/o_fab_lane_arbiter.sv
// Round-robin arbiter sharing one registered fabric-to-periphery output lane.
// Grants are bounded to MAX_BURST beats and followed by a GAP_CYCLES turnaround.
module o_fab_lane_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             ENABLE,
  input  logic [NUM_REQ-1:0]               REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_DATA,
  output logic [NUM_REQ-1:0]               REQ_READY,
  output logic [DATA_WIDTH-1:0]            O_DATA,
  output logic                             O_VALID,
  output logic [ID_WIDTH-1:0]              O_GRANT_ID,
  output logic                             BUSY
);

  localparam int unsigned BeatW   = $clog2(MAX_BURST + 1);
  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [ID_WIDTH-1:0] LastId = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [BeatW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [GapW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;

  logic [NUM_REQ-1:0]      rotated;
  logic                    pick_found;
  logic [ID_WIDTH-1:0]     pick_off;
  logic [ID_WIDTH:0]       pick_sum;
  logic [ID_WIDTH-1:0]     pick_id;
  logic                    owner_valid;
  logic [DATA_WIDTH-1:0]   owner_word;
  logic [BeatW-1:0]        beat_inc;
  logic                    release_burst;

  // Rotate requests so bit 0 is the requester at rr_ptr; first set bit wins.
  always_comb begin
    rotated    = NUM_REQ'({REQ_VALID, REQ_VALID} >> rr_ptr_q);
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!pick_found && rotated[i]) begin
        pick_found = 1'b1;
        pick_off   = ID_WIDTH'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= (ID_WIDTH + 1)'(NUM_REQ)) begin
      pick_sum = pick_sum - (ID_WIDTH + 1)'(NUM_REQ);
    end
    pick_id = pick_sum[ID_WIDTH-1:0];
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_word  = '0;
    REQ_READY   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        owner_valid  = REQ_VALID[i];
        owner_word   = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        REQ_READY[i] = (state_q == StXfer);
      end
    end
  end

  assign beat_inc = beat_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    release_burst = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ENABLE && pick_found) begin
          grant_d    = pick_id;
          beat_cnt_d = '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (owner_valid) begin
          data_d        = owner_word;
          valid_d       = 1'b1;
          beat_cnt_d    = beat_inc;
          release_burst = (beat_inc == BeatW'(MAX_BURST));
        end else begin
          release_burst = 1'b1;
        end
        if (release_burst) begin
          rr_ptr_d = (grant_q == LastId) ? '0 : grant_q + 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GapLast)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign O_DATA     = data_q;
  assign O_VALID    = valid_q;
  assign O_GRANT_ID = grant_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_o_fab_lane_arbiter.sv
// Bench for o_fab_lane_arbiter: default build plus a MAX_BURST=1/GAP_CYCLES=0 build
// sharing stimulus, with directed tables and a random run against a reference model.
module tb_o_fab_lane_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  rv = '0;
  logic [31:0] rd = '0;

  logic [3:0] ready_a, ready_b;
  logic [7:0] od_a, od_b;
  logic       ov_a, ov_b;
  logic [1:0] gid_a, gid_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  o_fab_lane_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .GAP_CYCLES(2), .ID_WIDTH(2)
  ) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en), .REQ_VALID(rv), .REQ_DATA(rd),
    .REQ_READY(ready_a), .O_DATA(od_a), .O_VALID(ov_a), .O_GRANT_ID(gid_a), .BUSY(busy_a)
  );

  o_fab_lane_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1), .GAP_CYCLES(0), .ID_WIDTH(2)
  ) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en), .REQ_VALID(rv), .REQ_DATA(rd),
    .REQ_READY(ready_b), .O_DATA(od_b), .O_VALID(ov_b), .O_GRANT_ID(gid_b), .BUSY(busy_b)
  );

  // Reference model: lane owner, beats used, and turnaround cycles still to wait.
  typedef struct {
    int         mode;      // 0 idle, 1 owner transferring, 2 turnaround
    int         ptr;
    int         owner;
    int         beats;
    int         gap_left;
    logic [7:0] data;
    logic       valid;
  } model_t;

  typedef struct {
    logic [3:0]  rv;
    logic [7:0]  w0;
    logic [15:0] exp;
  } vec_t;

  function automatic logic [15:0] pk(logic [3:0] r, logic v, logic [7:0] d, logic [1:0] g,
                                     logic b);
    return {r, v, d, g, b};
  endfunction

  function automatic logic [15:0] obs_a();
    return {ready_a, ov_a, od_a, gid_a, busy_a};
  endfunction

  function automatic logic [15:0] obs_b();
    return {ready_b, ov_b, od_b, gid_b, busy_b};
  endfunction

  function automatic model_t mreset();
    model_t m;
    m.mode = 0; m.ptr = 0; m.owner = 0; m.beats = 0; m.gap_left = 0;
    m.data = '0; m.valid = 1'b0;
    return m;
  endfunction

  function automatic logic [15:0] mexp(model_t m);
    logic [3:0] r;
    r = (m.mode == 1) ? 4'(1 << m.owner) : 4'b0000;
    return pk(r, m.valid, m.data, 2'(m.owner), m.mode != 0);
  endfunction

  function automatic model_t mstep(model_t m, logic [3:0] v, logic [31:0] d, logic e,
                                   int maxb, int gap);
    model_t n = m;
    bit     done = 1'b0;
    n.valid = 1'b0;
    if (m.mode == 0) begin
      if (e && v != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (!done && v[(m.ptr + k) % 4]) begin
            done    = 1'b1;
            n.owner = (m.ptr + k) % 4;
            n.beats = 0;
            n.mode  = 1;
          end
        end
      end
    end else if (m.mode == 1) begin
      if (v[m.owner]) begin
        n.data  = d[m.owner*8 +: 8];
        n.valid = 1'b1;
        n.beats = m.beats + 1;
        done    = (n.beats == maxb);
      end else begin
        done = 1'b1;
      end
      if (done) begin
        n.ptr = (m.owner + 1) % 4;
        if (gap > 0) begin
          n.mode = 2;
          n.gap_left = gap;
        end else begin
          n.mode = 0;
        end
      end
    end else begin
      n.gap_left = m.gap_left - 1;
      if (n.gap_left == 0) n.mode = 0;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    rv = '0;
    rd = '0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl[8];
    model_t ma, mb;
    int     cnt;
    logic   ovh[60];
    logic [1:0] gh[60];
    int     run_gid[$], run_len[$], gap_len[$];
    int     cur_gap;
    bit     started;
    int     exp_order[5] = '{0, 1, 2, 3, 0};

    tbl[0] = '{rv: 4'b0001, w0: 8'h11, exp: pk(4'b0001, 1'b0, 8'h00, 2'd0, 1'b1)};
    tbl[1] = '{rv: 4'b0001, w0: 8'h11, exp: pk(4'b0001, 1'b1, 8'h11, 2'd0, 1'b1)};
    tbl[2] = '{rv: 4'b0001, w0: 8'h22, exp: pk(4'b0001, 1'b1, 8'h22, 2'd0, 1'b1)};
    tbl[3] = '{rv: 4'b0001, w0: 8'h33, exp: pk(4'b0001, 1'b1, 8'h33, 2'd0, 1'b1)};
    tbl[4] = '{rv: 4'b0001, w0: 8'h44, exp: pk(4'b0000, 1'b1, 8'h44, 2'd0, 1'b1)};
    tbl[5] = '{rv: 4'b0001, w0: 8'h55, exp: pk(4'b0000, 1'b0, 8'h44, 2'd0, 1'b1)};
    tbl[6] = '{rv: 4'b0001, w0: 8'h55, exp: pk(4'b0000, 1'b0, 8'h44, 2'd0, 1'b0)};
    tbl[7] = '{rv: 4'b0001, w0: 8'h55, exp: pk(4'b0001, 1'b0, 8'h44, 2'd0, 1'b1)};

    // Reset values.
    #2;
    check("reset_a", obs_a(), 0);
    check("reset_b", obs_b(), 0);
    #1 rst_n = 1'b1;
    en = 1'b1;

    // Single burst from requester 0.
    for (int i = 0; i < 8; i++) begin
      rv = tbl[i].rv;
      rd = {24'h0, tbl[i].w0};
      tick();
      check($sformatf("burst_row%0d", i), obs_a(), tbl[i].exp);
    end

    // Asynchronous reset mid-cycle while owner 0 holds the lane.
    #3 rst_n = 1'b0;
    #1 check("async_reset", obs_a(), 0);
    rv = 4'b0001;
    rd = 32'h66;
    #1 rst_n = 1'b1;
    tick();
    check("post_reset_no_beat", obs_a(), pk(4'b0001, 1'b0, 8'h00, 2'd0, 1'b1));
    tick();
    check("post_reset_beat", obs_a(), pk(4'b0001, 1'b1, 8'h66, 2'd0, 1'b1));

    // Early release by requester 2, then requesters 1 and 3 compete.
    do_reset();
    en = 1'b1;
    rv = 4'b0100;
    rd = 32'h00A1_0000;
    tick();
    check("er_grant", obs_a(), pk(4'b0100, 1'b0, 8'h00, 2'd2, 1'b1));
    tick();
    check("er_beat1", obs_a(), pk(4'b0100, 1'b1, 8'hA1, 2'd2, 1'b1));
    rd = 32'h00A2_0000;
    tick();
    check("er_beat2", obs_a(), pk(4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1));
    rv = 4'b0000;
    tick();
    check("er_gap", obs_a(), pk(4'b0000, 1'b0, 8'hA2, 2'd2, 1'b1));
    rv = 4'b1010;
    rd = 32'hD300_B100;
    tick();
    tick();
    check("er_idle", obs_a(), pk(4'b0000, 1'b0, 8'hA2, 2'd2, 1'b0));
    tick();
    check("er_regrant3", obs_a(), pk(4'b1000, 1'b0, 8'hA2, 2'd3, 1'b1));
    tick();
    check("er_beat3", obs_a(), pk(4'b1000, 1'b1, 8'hD3, 2'd3, 1'b1));

    // ENABLE gates only new grants.
    do_reset();
    en = 1'b0;
    rv = 4'b0100;
    rd = 32'h0077_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_off", {busy_a, ready_a}, 0);
    end
    en = 1'b1;
    tick();
    check("en_grant", {busy_a, ready_a}, 5'b1_0100);
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov_a) cnt++;
    end
    check("en_burst_len", cnt, 4);
    check("en_stay_idle", {busy_a, ready_a}, 0);

    // Round-robin with all requesters active.
    do_reset();
    en = 1'b1;
    rv = 4'b1111;
    rd = 32'h4433_2211;
    for (int i = 0; i < 60; i++) begin
      tick();
      ovh[i] = ov_a;
      gh[i] = gid_a;
    end
    cur_gap = 0;
    started = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ovh[i]) begin
        if (i == 0 || !ovh[i-1]) begin
          if (started) gap_len.push_back(cur_gap);
          run_gid.push_back(int'(gh[i]));
          run_len.push_back(1);
        end else begin
          run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
        end
        cur_gap = 0;
        started = 1'b1;
      end else if (started) begin
        cur_gap++;
      end
    end
    check("rr_runs", (run_gid.size() >= 5) ? 1 : 0, 1);
    for (int k = 0; k < 5; k++) begin
      if (k < run_gid.size()) begin
        check($sformatf("rr_owner%0d", k), run_gid[k], exp_order[k]);
        check($sformatf("rr_len%0d", k), run_len[k], 4);
      end
      if (k < 4 && k < gap_len.size()) check($sformatf("rr_gap%0d", k), gap_len[k], 3);
    end

    // Single-beat, zero-gap build alternates between requesters 0 and 1.
    do_reset();
    en = 1'b1;
    rv = 4'b0011;
    rd = 32'h0000_BBAA;
    tick();
    check("b_first", ov_b, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("b_beat%0d", k), {ov_b, gid_b}, 4 + (k % 2));
      tick();
      check($sformatf("b_idle%0d", k), ov_b, 0);
    end

    // Random traffic against the reference model, both builds.
    do_reset();
    ma = mreset();
    mb = mreset();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
      rd = $urandom;
      ma = mstep(ma, rv, rd, en, 4, 2);
      mb = mstep(mb, rv, rd, en, 1, 0);
      tick();
      check("rand_a", obs_a(), mexp(ma));
      check("rand_b", obs_b(), mexp(mb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
